// File: rtl/dcache_mem_responder.sv
// dcache_mem_responder: round-robin memory responder for data-cache request channels,
// serving one request at a time against a fixed-latency single-port array.
module dcache_mem_responder #(
   parameter int ADDR_BITS    = 8,
   parameter int DATA_BITS    = 8,
   parameter int NUM_CHANNELS = 8,
   parameter int LATENCY      = 2
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [NUM_CHANNELS-1:0]                consumer_read_valid,
   input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] consumer_read_address,
   output logic [NUM_CHANNELS-1:0]                consumer_read_ready,
   output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] consumer_read_data,
   input  logic [NUM_CHANNELS-1:0]                consumer_write_valid,
   input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] consumer_write_address,
   input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] consumer_write_data,
   output logic [NUM_CHANNELS-1:0]                consumer_write_ready,
   input  logic                                   init_write_valid,
   input  logic [ADDR_BITS-1:0]                   init_write_address,
   input  logic [DATA_BITS-1:0]                   init_write_data
);
   localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
   localparam int LW = $clog2(LATENCY + 1);
   typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;
   state_t                                 state_q, state_d;
   logic [CW-1:0]                          ptr_q, ptr_d, gnt_q, gnt_d, sel, c;
   logic                                   op_wr_q, op_wr_d, found, commit;
   logic [ADDR_BITS-1:0]                   addr_q, addr_d;
   logic [DATA_BITS-1:0]                   data_q, data_d;
   logic [LW-1:0]                          cnt_q, cnt_d;
   logic [NUM_CHANNELS-1:0]                rd_rdy_q, rd_rdy_d, wr_rdy_q, wr_rdy_d;
   logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] rd_data_q, rd_data_d;
   logic [DATA_BITS-1:0]                   mem [2**ADDR_BITS];

   assign commit               = state_q == BUSY && cnt_q == LW'(1);
   assign consumer_read_ready  = rd_rdy_q;
   assign consumer_write_ready = wr_rdy_q;
   assign consumer_read_data   = rd_data_q;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gnt_d     = gnt_q;
      op_wr_d   = op_wr_q;
      addr_d    = addr_q;
      data_d    = data_q;
      cnt_d     = cnt_q;
      rd_rdy_d  = rd_rdy_q;
      wr_rdy_d  = wr_rdy_q;
      rd_data_d = rd_data_q;
      found     = 1'b0;
      sel       = '0;
      c         = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         c = CW'((int'(ptr_q) + i) % NUM_CHANNELS);
         if (!found && (consumer_read_valid[c] || consumer_write_valid[c])) begin
            found = 1'b1;
            sel   = c;
         end
      end
      case (state_q)
         IDLE: if (found) begin
            gnt_d   = sel;
            op_wr_d = consumer_write_valid[sel];
            addr_d  = consumer_write_valid[sel] ? consumer_write_address[sel] : consumer_read_address[sel];
            data_d  = consumer_write_data[sel];
            cnt_d   = LW'(LATENCY);
            state_d = BUSY;
         end
         BUSY: begin
            cnt_d = cnt_q - 1'b1;
            if (commit) begin
               state_d = RESPOND;
               if (op_wr_q) wr_rdy_d[gnt_q] = 1'b1;
               else begin
                  rd_rdy_d[gnt_q]  = 1'b1;
                  rd_data_d[gnt_q] = mem[addr_q];
               end
            end
         end
         RESPOND: if (!(op_wr_q ? consumer_write_valid[gnt_q] : consumer_read_valid[gnt_q])) begin
            rd_rdy_d = '0;
            wr_rdy_d = '0;
            ptr_d    = gnt_q == CW'(NUM_CHANNELS - 1) ? '0 : gnt_q + 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         gnt_q     <= '0;
         op_wr_q   <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         cnt_q     <= '0;
         rd_rdy_q  <= '0;
         wr_rdy_q  <= '0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gnt_q     <= gnt_d;
         op_wr_q   <= op_wr_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         cnt_q     <= cnt_d;
         rd_rdy_q  <= rd_rdy_d;
         wr_rdy_q  <= wr_rdy_d;
         rd_data_q <= rd_data_d;
      end
   end

   // Array survives reset; a consumer write committing with a backdoor load to the same word wins.
   always_ff @(posedge clk) begin
      if (init_write_valid) mem[init_write_address] <= init_write_data;
      if (commit && op_wr_q) mem[addr_q] <= data_q;
   end
endmodule

// File: doc/dcache_mem_responder.md
Name: dcache_mem_responder

Overview:
- Memory-side responder for the data cache's controller interface. It accepts the cache's per-channel read/write miss and writeback requests and services them one at a time against an internal single-port memory array with fixed access latency.
- Grant order across channels is round-robin.
- Used as the global-memory model in cache unit and GPU-level benches, and as the reference behaviour for the real memory controller.

Parameters:
- ADDR_BITS, 8, address width; memory depth is 2**ADDR_BITS words.
- DATA_BITS, 8, word width.
- NUM_CHANNELS, 8, number of request channels; matches the cache's NUM_CHANNELS.
- LATENCY, 2, cycles from grant to ready; legal range is LATENCY >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- consumer_read_valid  input  [NUM_CHANNELS]  per-channel read request.
- consumer_read_address  input  [NUM_CHANNELS][ADDR_BITS]  read address.
- consumer_read_ready  output  [NUM_CHANNELS]  read complete / data valid.
- consumer_read_data  output  [NUM_CHANNELS][DATA_BITS]  read data, registered per channel.
- consumer_write_valid  input  [NUM_CHANNELS]  per-channel write request.
- consumer_write_address  input  [NUM_CHANNELS][ADDR_BITS]  write address.
- consumer_write_data  input  [NUM_CHANNELS][DATA_BITS]  write data.
- consumer_write_ready  output  [NUM_CHANNELS]  write committed.
- init_write_valid  input  1  backdoor memory load strobe.
- init_write_address  input  ADDR_BITS  backdoor address.
- init_write_data  input  DATA_BITS  backdoor data.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; all ready outputs 0; all consumer_read_data 0; round-robin pointer 0; latched request cleared.
  - Memory array is not cleared.
  - Reset mid-operation abandons the request in flight. An uncommitted write is lost; no ready is ever issued for it.
- Handshake:
  - Requester holds valid and address/data stable until it sees ready.
  - Ready stays high until the responder samples valid low.
  - Ready then drops on that same edge.
- FSM states: IDLE, BUSY, RESPOND.
- IDLE:
  - At each edge, scan channels starting from the round-robin pointer, wrapping modulo NUM_CHANNELS.
  - The first channel with read or write valid is granted.
  - If that channel has both valids high, the write is granted and the read waits for a later grant.
  - On grant, latch channel index, op, address and data; load counter=LATENCY; go to BUSY.
  - With no valid, stay in IDLE.
- BUSY:
  - Each edge decrements the counter.
  - On the edge where the counter reaches 0, perform the access:
    - Read: consumer_read_data[g] <= mem[addr].
    - Write: mem[addr] <= data.
  - On that same edge, set the matching ready[g]=1 and go to RESPOND.
  - Ready is therefore visible exactly LATENCY cycles after the grant edge.
- RESPOND:
  - Hold ready[g] high while the matching valid[g] is high.
  - On the edge where valid[g] is sampled low: ready[g] <= 0, pointer <= (g+1) mod NUM_CHANNELS, go to IDLE.
  - Next arbitration happens at the following edge, so back-to-back requests are spaced LATENCY+2 cycles minimum.
- Valid deasserted during BUSY:
  - The access still completes (write still commits).
  - Ready pulses high for exactly one cycle, then RESPOND exits on the next edge.
- Only one ready bit is ever high at a time.
- consumer_read_data[c] holds its value until channel c's next read completes; it is unaffected by other channels.
- Backdoor load:
  - init_write_valid writes mem[init_write_address] at any edge, in any state, including during reset.
  - If it coincides with a consumer write commit to the same address, the consumer write wins.
  - A read committing on the same edge as an init write to its address returns the old value.

Test Plan:
- Preload mem[0x10]=0xAB via backdoor. Ch0 read 0x10, LATENCY=2, grant at edge E -> read_ready[0] rises after edge E+2 with read_data[0]=0xAB. Drop valid -> ready low one edge later.
- Ch3 write 0x20<-0x5C, then ch3 read 0x20 -> write_ready[3] pulse sequence, then read_data[3]=0x5C.
- Ch1, ch2 and ch5 all raise read valid in the same cycle with pointer=0 -> service order 1, 2, 5. Next simultaneous ch1 and ch2 requests with pointer=6 -> order 1, 2. Never two ready bits high at once.
- Ch4 raises write and read valid simultaneously, both on 0x30 (write 0x77) -> write granted first; the later read returns 0x77.
- Reset asserted during BUSY of ch2 write 0x40<-0x99 (mem[0x40]=0x11 preloaded) -> all readies 0 immediately; mem[0x40] stays 0x11. After release, a ch2 read of 0x40 returns 0x11.
- Ch6 read valid dropped one cycle after grant -> read_ready[6] high for exactly one cycle; FSM returns to IDLE; the next request from ch7 is served normally.
